// File: rtl/gate_sweep_ctrl_if.sv
// rtl/gate_sweep_ctrl_if.sv - control, status and gate-under-test signals of the sweep sequencer
// Purpose: bundles every non-clock/reset signal of gate_sweep_ctrl.
// Signals:
//   start, abort        self-test logic -> sequencer
//   busy, done, pass    sequencer -> self-test logic
//   err_cnt, fail_vec   sequencer -> self-test logic
//   gate_in             sequencer -> gate under test
//   gate_out            gate under test -> sequencer
// Modports: slave = sequencer side, master = self-test / gate side.
interface gate_sweep_ctrl_if #(
    parameter int N_IN = 2
) ();
    logic            start;
    logic            abort;
    logic [N_IN-1:0] gate_in;
    logic            gate_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] fail_vec;

    modport slave (
        input  start, abort, gate_out,
        output gate_in, busy, done, pass, err_cnt, fail_vec
    );

    modport master (
        output start, abort, gate_out,
        input  gate_in, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - exhaustive-test sequencer for a small combinational gate
// Purpose: drives every input vector 0..2^N_IN-1 in ascending order, holds each for
//   SETTLE cycles, then compares the gate output with the EXPECTED truth table.
//   Reports pass/fail, a mismatch count and the first failing vector.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   gate_sweep_ctrl_if.slave (start/abort in, gate_in/gate_out to the gate,
//         busy/done/pass/err_cnt/fail_vec status out); all outputs are registered.
module gate_sweep_ctrl #(
    parameter int                   N_IN     = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 4'b0111,
    parameter int                   SETTLE   = 2
) (
    input  logic              clk,
    input  logic              rst,
    gate_sweep_ctrl_if.slave  bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_APPLY  = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]      state_q,    state_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [N_IN-1:0] gate_in_q,  gate_in_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            pass_q,     pass_d;
    logic [N_IN:0]   err_cnt_q,  err_cnt_d;
    logic [N_IN-1:0] fail_vec_q, fail_vec_d;

    logic mismatch;
    assign mismatch = (bus.gate_out != EXPECTED[gate_in_q]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gate_in_d  = gate_in_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_vec_d = fail_vec_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    gate_in_d  = '0;
                    cnt_d      = '0;
                    err_cnt_d  = '0;
                    fail_vec_d = '0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_APPLY;
                end
            end
            S_APPLY: begin
                if (bus.abort) begin
                    busy_d    = 1'b0;
                    gate_in_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(SETTLE - 1))
                        state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Abort wins over the check: the vector being checked is not scored.
                if (bus.abort) begin
                    busy_d    = 1'b0;
                    gate_in_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    if (mismatch) begin
                        err_cnt_d = err_cnt_q + (N_IN+1)'(1);
                        if (err_cnt_q == '0)
                            fail_vec_d = gate_in_q;
                    end
                    if (gate_in_q == {N_IN{1'b1}}) begin
                        // done/pass are registered here so they appear in the FINISH cycle
                        // and already include this last comparison.
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == '0);
                        state_d = S_FINISH;
                    end else begin
                        gate_in_d = gate_in_q + N_IN'(1);
                        cnt_d     = '0;
                        state_d   = S_APPLY;
                    end
                end
            end
            default: begin
                busy_d    = 1'b0;
                gate_in_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            gate_in_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_vec_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gate_in_q  <= gate_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    assign bus.gate_in  = gate_in_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.fail_vec = fail_vec_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - directed self-checking bench for gate_sweep_ctrl
module tb_gate_sweep_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   errors;
    int   mode;   // 0 = NAND (correct), 1 = stuck at 1, 2 = AND (inverted)

    gate_sweep_ctrl_if #(.N_IN(2)) bus ();

    gate_sweep_ctrl #(.N_IN(2), .EXPECTED(4'b0111), .SETTLE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.gate_out = (mode == 0) ? ~(bus.gate_in[1] & bus.gate_in[0]) :
                          (mode == 1) ? 1'b1 :
                                        (bus.gate_in[1] & bus.gate_in[0]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full sweep from IDLE: start is sampled at edge 0, done appears after edge 12.
    task automatic sweep(input logic [31:0] exp_err, input logic [31:0] exp_fv,
                         input logic exp_pass, input bit repulse);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_pass_clr", 32'(bus.pass), 0);
        check("start_err_clr", 32'(bus.err_cnt), 0);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("gate_in_c%0d", k), 32'(bus.gate_in), 32'(k / 3));
            check($sformatf("busy_c%0d", k), 32'(bus.busy), 1);
            check($sformatf("done_c%0d", k), 32'(bus.done), 0);
            bus.start = repulse && (k == 2 || k == 10);
            tick();
        end
        bus.start = 1'b0;
        check("done_at_12", 32'(bus.done), 1);
        check("busy_at_12", 32'(bus.busy), 1);
        check("pass_at_12", 32'(bus.pass), 32'(exp_pass));
        check("err_cnt", 32'(bus.err_cnt), exp_err);
        check("fail_vec", 32'(bus.fail_vec), exp_fv);
        tick();
        check("done_pulse_end", 32'(bus.done), 0);
        check("busy_end", 32'(bus.busy), 0);
        check("gate_in_end", 32'(bus.gate_in), 0);
        check("pass_held", 32'(bus.pass), 32'(exp_pass));
        tick();
        check("no_second_done", 32'(bus.done), 0);
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        mode      = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_gate_in", 32'(bus.gate_in), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_pass", 32'(bus.pass), 0);
        check("rst_err_cnt", 32'(bus.err_cnt), 0);
        check("rst_fail_vec", 32'(bus.fail_vec), 0);

        // 1: correct NAND
        mode = 0;
        sweep(0, 0, 1'b1, 1'b0);
        // 2: stuck at 1, only vector 11 wrong
        mode = 1;
        sweep(1, 3, 1'b0, 1'b0);
        // 3: AND, every vector wrong
        mode = 2;
        sweep(4, 0, 1'b0, 1'b0);
        // 4: start re-pulsed while busy is ignored
        mode = 0;
        sweep(0, 0, 1'b1, 1'b1);

        // 5: abort in vector 2 CHECK (AND model mismatches there)
        mode = 2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("pre_abort_gate_in", 32'(bus.gate_in), 2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_gate_in", 32'(bus.gate_in), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_pass", 32'(bus.pass), 0);
        check("abort_fail_vec", 32'(bus.fail_vec), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("abort_idle_done%0d", k), 32'(bus.done), 0);
            check($sformatf("abort_idle_busy%0d", k), 32'(bus.busy), 0);
        end
        mode = 0;
        sweep(0, 0, 1'b1, 1'b0);

        // 6: reset mid-APPLY of vector 1
        mode = 2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("pre_rst_gate_in", 32'(bus.gate_in), 1);
        check("pre_rst_err", 32'(bus.err_cnt), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_gate_in", 32'(bus.gate_in), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_done", 32'(bus.done), 0);
        check("mid_rst_pass", 32'(bus.pass), 0);
        check("mid_rst_err_cnt", 32'(bus.err_cnt), 0);
        check("mid_rst_fail_vec", 32'(bus.fail_vec), 0);
        tick();
        check("post_rst_idle", 32'(bus.busy), 0);
        mode = 0;
        sweep(0, 0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
